pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Parametrised program-counter unit for the pipelined core; successor to the single-cycle PC register. Holds the fetch address and presents it to instruction memory with a valid/ready handshake. Applies stall, branch/jump redirect, trap vectoring, halt/resume and misaligned-target detection. Keeps a count of accepted fetches.

Parameters:
ADDR_W, 64, width of PC and all address ports
INSN_BYTES, 4, instruction size in bytes (power of two, ≥1); sequential increment and alignment unit
RESET_VEC, 0, PC value loaded on reset
TRAP_VEC, 64'h100, PC loaded on trap or misaligned redirect (truncated to ADDR_W)
CNT_W, 32, width of fetch counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
pc  out  ADDR_W  current fetch address
pc_valid  out  1  pc is a valid fetch request
pc_ready  in  1  fetch stage accepts pc this cycle
redirect  in  1  branch/jump taken; load redirect_target
redirect_target  in  ADDR_W  new fetch address
trap  in  1  exception; load TRAP_VEC
halt_req  in  1  request to stop fetching
resume  in  1  leave HALT
halted  out  1  unit is in HALT
misalign_err  out  1  one-cycle pulse: redirect target misaligned
bad_addr  out  ADDR_W  last misaligned target
fetch_cnt  out  CNT_W  number of accepted fetches

Behaviour:
- Reset (async, rst=1): state=BOOT; pc=RESET_VEC; pc_valid=0; halted=0; misalign_err=0; bad_addr=0; fetch_cnt=0. Holds while rst=1.
- States: BOOT, RUN, HALT. Registered outputs only; pc_valid=1 iff state==RUN.
- BOOT: exactly one cycle after rst deasserts, then RUN. Inputs ignored in BOOT.
- Accept: acc = pc_valid & pc_ready. fetch_cnt += 1 on acc, wraps modulo 2^CNT_W.
- RUN next-PC priority, evaluated each cycle:
  1. trap: pc <- TRAP_VEC.
  2. redirect with target[log2(INSN_BYTES)-1:0] != 0: pc <- TRAP_VEC, bad_addr <- target, misalign_err=1 next cycle.
  3. redirect, aligned: pc <- redirect_target.
  4. acc: pc <- pc + INSN_BYTES, modulo 2^ADDR_W (all-ones region wraps to 0).
  5. else: pc holds (stall).
- Redirect/trap in the same cycle as acc: fetch still counted; the sequential increment is discarded.
- halt_req in RUN, no trap/redirect: next state HALT, halted=1, pc_valid=0. pc = pc+INSN_BYTES if acc else held.
- halt_req with redirect/trap in the same cycle: the redirect/trap PC update applies, and the unit still enters HALT.
- HALT:
  - redirect (aligned) updates pc, stays HALT.
  - misaligned redirect: same effect as in RUN, stays HALT.
  - trap: pc <- TRAP_VEC, state -> RUN (trap overrides halt).
  - resume (no trap): -> RUN next cycle.
  - halt_req and resume together: stay HALT.
  - pc_ready ignored.
- misalign_err is high for exactly one cycle per offending redirect. bad_addr holds until the next misaligned redirect or reset.
- Reset mid-operation: immediate return to reset values regardless of state or handshake.

Optional Feature:
PC_TRACE_EN
- Defined: simulation-only $display on every pc update, showing time, old pc, new pc (hex) and cause (SEQ/BR/TRAP/MIS). Also prints on state changes.
- Undefined: no display statements; RTL identical in function.

Test Plan:
- Reset then release, pc_ready=1 for 4 cycles, ADDR_W=64, INSN_BYTES=4 -> BOOT 1 cycle; pc sequence 0,4,8,C; fetch_cnt=4.
- pc_ready=0 for 3 cycles in RUN at pc=0x20 -> pc stays 0x20, pc_valid=1, fetch_cnt unchanged.
- redirect=1, target=0x400, together with acc at pc=0x10 -> next pc=0x400 (not 0x14); fetch_cnt increments.
- redirect target=0x402 -> next pc=0x100; misalign_err pulses 1 cycle; bad_addr=0x402.
- halt_req at pc=0x40 with acc -> halted=1, pc=0x44, pc_valid=0. redirect 0x80 while halted -> pc=0x80, still halted. resume -> RUN, pc_valid=1 at 0x80. trap in HALT -> pc=0x100 and RUN.
- Wrap: redirect to 0xFFFF_FFFF_FFFF_FFFC, acc -> pc=0. rst asserted asynchronously mid-stall -> pc=RESET_VEC and pc_valid=0 before the next clock edge.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program-counter unit: holds the fetch address, handshakes it to instruction memory and
// applies stall, redirect, trap, halt/resume and misaligned-target handling. Optional trace: PC_TRACE_EN.
module pc_fetch_unit #(
   parameter int          ADDR_W     = 64,
   parameter int          INSN_BYTES = 4,
   parameter logic [63:0] RESET_VEC  = 64'h0,
   parameter logic [63:0] TRAP_VEC   = 64'h100,
   parameter int          CNT_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] pc,
   output logic              pc_valid,
   input  logic              pc_ready,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_target,
   input  logic              trap,
   input  logic              halt_req,
   input  logic              resume,
   output logic              halted,
   output logic              misalign_err,
   output logic [ADDR_W-1:0] bad_addr,
   output logic [CNT_W-1:0]  fetch_cnt
);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSN_BYTES - 1);
   localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INSN_BYTES);
   localparam logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_VEC);
   localparam logic [ADDR_W-1:0] TRAP_PC    = ADDR_W'(TRAP_VEC);

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   pc_nxt, bad_nxt;
   logic [CNT_W-1:0]    cnt_nxt;
   logic                err_nxt, acc, misaligned;

   // Next-state and next-PC selection; in BOOT every input is ignored.
   always_comb begin
      acc        = pc_valid & pc_ready;
      misaligned = redirect && ((redirect_target & ALIGN_MASK) != '0);
      state_nxt  = state;
      pc_nxt     = pc;
      bad_nxt    = bad_addr;
      err_nxt    = 1'b0;
      cnt_nxt    = fetch_cnt + CNT_W'(acc);
      unique case (state)
         BOOT: state_nxt = RUN;
         RUN, HALT: begin
            if (trap) begin
               pc_nxt = TRAP_PC;
            end else if (misaligned) begin
               pc_nxt  = TRAP_PC;
               bad_nxt = redirect_target;
               err_nxt = 1'b1;
            end else if (redirect) begin
               pc_nxt = redirect_target;
            end else if (acc) begin
               pc_nxt = pc + STEP;
            end
            // A trap always wins over halt while halted; in RUN a halt request wins.
            if (state == RUN) begin
               if (halt_req) state_nxt = HALT;
            end else if (trap || (resume && !halt_req)) begin
               state_nxt = RUN;
            end
         end
         default: state_nxt = BOOT;
      endcase
   end

   // All outputs are registered, including the state-derived handshake flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= BOOT;
         pc           <= RESET_PC;
         pc_valid     <= 1'b0;
         halted       <= 1'b0;
         misalign_err <= 1'b0;
         bad_addr     <= '0;
         fetch_cnt    <= '0;
      end else begin
         state        <= state_nxt;
         pc           <= pc_nxt;
         pc_valid     <= (state_nxt == RUN);
         halted       <= (state_nxt == HALT);
         misalign_err <= err_nxt;
         bad_addr     <= bad_nxt;
         fetch_cnt    <= cnt_nxt;
      end
   end

`ifdef PC_TRACE_EN
   // Simulation trace of PC updates and state transitions.
   always @(posedge clk) begin
      if (!rst) begin
         if (pc_nxt != pc)
            $display("[PC] t=%0t pc %h -> %h %s", $time, pc, pc_nxt,
                     trap ? "TRAP" : misaligned ? "MIS" : redirect ? "BR" : "SEQ");
         if (state_nxt != state)
            $display("[PC] t=%0t state %s -> %s", $time, state.name(), state_nxt.name());
      end
   end
`else
   // Trace disabled: no simulation output.
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: a spec-level model checked every negedge,
// plus literal expectations along a directed sequence.
module tb_pc_fetch_unit;

   localparam int MBOOT = 0, MRUN = 1, MHALT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] pc;
   logic        pc_valid, pc_ready, redirect, trap, halt_req, resume, halted, misalign_err;
   logic [63:0] redirect_target, bad_addr;
   logic [31:0] fetch_cnt;

   int          checks = 0;
   int          failures = 0;
   bit          modelOn = 1'b0;
   int          mState;
   logic [63:0] mPc, mBad;
   logic [31:0] mCnt;
   logic        mErr;

   pc_fetch_unit dut (
      .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
      .redirect(redirect), .redirect_target(redirect_target), .trap(trap),
      .halt_req(halt_req), .resume(resume), .halted(halted),
      .misalign_err(misalign_err), .bad_addr(bad_addr), .fetch_cnt(fetch_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      mState = MBOOT; mPc = 64'h0; mBad = 64'h0; mCnt = 32'h0; mErr = 1'b0;
   endtask

   // Spec-level behaviour of one clock edge.
   task automatic modelStep(input logic r, input logic [63:0] t, input logic tp,
                            input logic hr, input logic rs, input logic rdy);
      bit accepted, bad;
      accepted = (mState == MRUN) && rdy;
      bad      = r && ((t % 64'd4) != 0);
      mErr     = 1'b0;
      if (accepted) mCnt = mCnt + 1;
      if (mState == MBOOT) begin
         mState = MRUN;
      end else begin
         if (tp)            mPc = 64'h100;
         else if (bad)      begin mPc = 64'h100; mBad = t; mErr = 1'b1; end
         else if (r)        mPc = t;
         else if (accepted) mPc = mPc + 64'd4;
         if (mState == MRUN) mState = hr ? MHALT : MRUN;
         else if (tp)        mState = MRUN;
         else if (rs && !hr) mState = MRUN;
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [63:0] t, input logic tp,
                                input logic hr, input logic rs, input logic rdy);
      redirect = r; redirect_target = t; trap = tp; halt_req = hr; resume = rs; pc_ready = rdy;
      @(posedge clk);
      if (rst) modelReset();
      else     modelStep(r, t, tp, hr, rs, rdy);
      #1;
   endtask

   // Model comparison on every falling edge.
   always @(negedge clk) begin
      if (modelOn) begin
         checkOutput("pc", pc, mPc);
         checkOutput("pc_valid", {63'b0, pc_valid}, {63'b0, mState == MRUN});
         checkOutput("halted", {63'b0, halted}, {63'b0, mState == MHALT});
         checkOutput("misalign_err", {63'b0, misalign_err}, {63'b0, mErr});
         checkOutput("bad_addr", bad_addr, mBad);
         checkOutput("fetch_cnt", {32'b0, fetch_cnt}, {32'b0, mCnt});
      end
   end

   initial begin
      rst = 1'b1; redirect = 0; redirect_target = 0; trap = 0; halt_req = 0; resume = 0; pc_ready = 0;
      modelReset();
      #1 modelOn = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("lit_reset_valid", {63'b0, pc_valid}, 64'h0);
      checkOutput("lit_reset_pc", pc, 64'h0);

      rst = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("lit_boot_valid", {63'b0, pc_valid}, 64'h1);
      checkOutput("lit_boot_cnt", {32'b0, fetch_cnt}, 64'h0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("lit_seq_pc", pc, 64'h10);
      checkOutput("lit_seq_cnt", {32'b0, fetch_cnt}, 64'd4);

      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("lit_stall_pc", pc, 64'h20);
      checkOutput("lit_stall_cnt", {32'b0, fetch_cnt}, 64'd8);

      applyStimulus(1, 64'h10, 0, 0, 0, 0);
      applyStimulus(1, 64'h400, 0, 0, 0, 1);
      checkOutput("lit_br_pc", pc, 64'h400);
      checkOutput("lit_br_cnt", {32'b0, fetch_cnt}, 64'd9);

      applyStimulus(1, 64'h402, 0, 0, 0, 0);
      checkOutput("lit_mis_pc", pc, 64'h100);
      checkOutput("lit_mis_err", {63'b0, misalign_err}, 64'h1);
      checkOutput("lit_mis_bad", bad_addr, 64'h402);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("lit_mis_pulse", {63'b0, misalign_err}, 64'h0);

      applyStimulus(1, 64'h40, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 0, 1);
      checkOutput("lit_halt_pc", pc, 64'h44);
      checkOutput("lit_halt_flag", {63'b0, halted}, 64'h1);
      applyStimulus(1, 64'h80, 0, 0, 0, 1);
      checkOutput("lit_halt_br", pc, 64'h80);
      applyStimulus(0, 0, 0, 0, 1, 0);
      checkOutput("lit_resume_valid", {63'b0, pc_valid}, 64'h1);
      applyStimulus(0, 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      checkOutput("lit_trap_halt_pc", pc, 64'h100);
      checkOutput("lit_trap_halt_run", {63'b0, pc_valid}, 64'h1);

      applyStimulus(0, 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 1, 1, 1);
      applyStimulus(1, 64'h81, 0, 0, 0, 0);
      checkOutput("lit_halt_mis_bad", bad_addr, 64'h81);
      applyStimulus(0, 0, 0, 0, 1, 0);
      applyStimulus(1, 64'h200, 1, 1, 0, 1);
      applyStimulus(0, 0, 0, 0, 1, 0);
      applyStimulus(1, 64'h303, 1, 0, 0, 1);

      applyStimulus(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("lit_wrap_pc", pc, 64'h0);
      applyStimulus(0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);

      #2 rst = 1'b1;
      modelReset();
      #1;
      checkOutput("lit_async_pc", pc, 64'h0);
      checkOutput("lit_async_valid", {63'b0, pc_valid}, 64'h0);
      checkOutput("lit_async_cnt", {32'b0, fetch_cnt}, 64'h0);
      applyStimulus(0, 0, 0, 0, 0, 1);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("lit_rerun_pc", pc, 64'h8);

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
